// File: rtl/axis_tx_pkt_arb.sv
// axis_tx_pkt_arb: two-input, packet-locked, round-robin AXI-Stream arbiter
// feeding the LMAC TX path. Packets longer than MAX_PKT_BEATS are cut with a
// forced tlast, and the remainder of the source packet is drained.
//
// Ports:
//   clk, reset                  single clock, asynchronous active-high reset
//   s0_axis_* / s1_axis_*       requester AXI-Stream slaves (64-bit data, 8-bit keep)
//   m_axis_*                    AXI-Stream master toward LMAC TX
//   grant                       one-hot active grant (bit0 = port 0, bit1 = port 1)
//   pkt_cnt0 / pkt_cnt1         wrapping count of packets forwarded per port
//   oversize_err                one-cycle pulse after a packet is truncated
module axis_tx_pkt_arb #(
  parameter int unsigned MAX_PKT_BEATS = 190,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [7:0]       s0_axis_tkeep,
  input  logic             s0_axis_tlast,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [7:0]       s1_axis_tkeep,
  input  logic             s1_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             oversize_err
);

  localparam int unsigned BEAT_W = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT0   = 3'd1,
    GRANT1   = 3'd2,
    DISCARD0 = 3'd3,
    DISCARD1 = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;  // 0 = port 0, 1 = port 1
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
  logic               oversize_q, oversize_d;
  logic               at_max;
  logic               m_hs;

  assign at_max = (beat_cnt_q == BEAT_W'(MAX_PKT_BEATS - 1));

  // Beat path: a pure mux selected by the registered state, so no latency is added.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    unique case (state_q)
      GRANT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast | at_max;
        s0_axis_tready = m_axis_tready;
        grant          = 2'b01;
      end
      GRANT1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast | at_max;
        s1_axis_tready = m_axis_tready;
        grant          = 2'b10;
      end
      DISCARD0: s0_axis_tready = 1'b1;
      DISCARD1: s1_axis_tready = 1'b1;
      default: ;
    endcase
  end

  assign m_hs = m_axis_tvalid & m_axis_tready;

  // Arbitration, packet lock, truncation and counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    oversize_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, the port that was not granted last time wins.
        if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant_q)) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
          beat_cnt_d   = '0;
        end else if (s1_axis_tvalid) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
          beat_cnt_d   = '0;
        end
      end
      GRANT0: begin
        if (m_hs) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (m_axis_tlast) pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
          if (s0_axis_tlast) begin
            state_d = IDLE;
          end else if (at_max) begin
            state_d    = DISCARD0;
            oversize_d = 1'b1;
          end
        end
      end
      GRANT1: begin
        if (m_hs) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (m_axis_tlast) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
          if (s1_axis_tlast) begin
            state_d = IDLE;
          end else if (at_max) begin
            state_d    = DISCARD1;
            oversize_d = 1'b1;
          end
        end
      end
      DISCARD0: if (s0_axis_tvalid && s0_axis_tlast) state_d = IDLE;
      DISCARD1: if (s1_axis_tvalid && s1_axis_tlast) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      oversize_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      oversize_q   <= oversize_d;
    end
  end

  assign pkt_cnt0     = pkt_cnt0_q;
  assign pkt_cnt1     = pkt_cnt1_q;
  assign oversize_err = oversize_q;

endmodule

// File: tb/tb_axis_tx_pkt_arb.sv
// Testbench for axis_tx_pkt_arb: packets are generated per port, the expected
// output beats (truncation applied) are queued per port, and a monitor checks
// every output handshake, arbitration order, bubbles, hold under backpressure,
// oversize pulses and packet counters.
module tb_axis_tx_pkt_arb;

  localparam int unsigned MAX = 6;
  localparam int unsigned CW  = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } src_beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        forced;
  } exp_beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sv;
  logic [63:0]   sd [2];
  logic [7:0]    sk [2];
  logic [1:0]    sl;
  logic          s0_tready, s1_tready;
  logic          m_tvalid, m_tready, m_tlast, oversize_err;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  src_beat_t     src_q [2][$];
  exp_beat_t     exp_q [2][$];
  int            ord_q [$];
  logic [CW-1:0] model_cnt [2];
  int unsigned   gap_pct = 0;
  int            tr_mode = 0;  // 0 = always ready, 1 = toggle, 2 = random
  int            seq = 0;
  int            checks = 0;
  int            errors = 0;

  axis_tx_pkt_arb #(.MAX_PKT_BEATS(MAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s0_axis_tvalid(sv[0]), .s0_axis_tready(s0_tready), .s0_axis_tdata(sd[0]),
    .s0_axis_tkeep(sk[0]), .s0_axis_tlast(sl[0]),
    .s1_axis_tvalid(sv[1]), .s1_axis_tready(s1_tready), .s1_axis_tdata(sd[1]),
    .s1_axis_tkeep(sk[1]), .s1_axis_tlast(sl[1]),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .oversize_err(oversize_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet of len beats leaves as min(len, MAX) beats, tlast on
  // its own last beat or on beat MAX; every packet is counted once.
  task automatic push_pkt(input int p, input int len);
    src_beat_t s;
    exp_beat_t e;
    for (int i = 0; i < len; i++) begin
      s.data = {8'(p), 24'(seq), 32'($urandom)};
      s.keep = 8'($urandom);
      s.last = (i == len - 1);
      src_q[p].push_back(s);
      if (i < int'(MAX)) begin
        e.data   = s.data;
        e.keep   = s.keep;
        e.last   = s.last || (i == int'(MAX) - 1);
        e.forced = (i == int'(MAX) - 1) && (len > int'(MAX));
        exp_q[p].push_back(e);
      end
    end
    model_cnt[p] = model_cnt[p] + CW'(1);
    seq++;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(n < 3000, "quiet_timeout", 64'(n), 64'(3000));
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic check_counts(input string tag);
    chk(pkt_cnt0 == model_cnt[0], {tag, "_pkt_cnt0"}, 64'(pkt_cnt0), 64'(model_cnt[0]));
    chk(pkt_cnt1 == model_cnt[1], {tag, "_pkt_cnt1"}, 64'(pkt_cnt1), 64'(model_cnt[1]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk(grant == 2'b00, {tag, "_grant"}, 64'(grant), 64'(0));
    chk(m_tvalid == 1'b0, {tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({s0_tready, s1_tready} == 2'b00, {tag, "_s_tready"}, 64'({s0_tready, s1_tready}), 64'(0));
    chk(pkt_cnt0 == '0 && pkt_cnt1 == '0, {tag, "_pkt_cnts"}, 64'({pkt_cnt1, pkt_cnt0}), 64'(0));
    chk(oversize_err == 1'b0, {tag, "_oversize"}, 64'(oversize_err), 64'(0));
  endtask

  // Source drivers and m_tready generator: inputs change 1 time unit after posedge.
  initial begin : drv
    logic [1:0] hs;
    sv = '0; sl = '0; sd[0] = '0; sd[1] = '0; sk[0] = '0; sk[1] = '0;
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      hs = sv & {s1_tready, s0_tready};
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (hs[p] && src_q[p].size() > 0) begin
          void'(src_q[p].pop_front());
          sv[p] = 1'b0;
        end
        if (src_q[p].size() > 0) begin
          if (!sv[p]) sv[p] = ($urandom_range(99) >= gap_pct);
          sd[p] = src_q[p][0].data;
          sk[p] = src_q[p][0].keep;
          sl[p] = src_q[p][0].last;
        end else begin
          sv[p] = 1'b0;
        end
      end
      case (tr_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(99) < 70);
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin : mon
    bit          after_last, stall_prev, exp_ovf, first_beat;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    int          gp, eo;
    exp_beat_t   e;
    after_last = 0; stall_prev = 0; exp_ovf = 0; first_beat = 1;
    pd = '0; pk = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        after_last = 0; stall_prev = 0; exp_ovf = 0; first_beat = 1;
      end else begin
        chk(oversize_err == exp_ovf, "oversize_err", 64'(oversize_err), 64'(exp_ovf));
        if (stall_prev) begin
          chk(m_tvalid == 1'b1, "stall_valid", 64'(m_tvalid), 64'(1));
          chk(m_tdata == pd && m_tkeep == pk && m_tlast == pl, "stall_hold", m_tdata, pd);
        end
        if (after_last)
          chk(!m_tvalid && grant == 2'b00, "bubble", 64'({grant, m_tvalid}), 64'(0));
        after_last = 0;
        exp_ovf    = 0;
        if (grant == 2'b01)
          chk(!s1_tready && s0_tready == m_tready, "tready_route0",
              64'({s1_tready, s0_tready}), 64'({1'b0, m_tready}));
        if (grant == 2'b10)
          chk(!s0_tready && s1_tready == m_tready, "tready_route1",
              64'({s1_tready, s0_tready}), 64'({m_tready, 1'b0}));
        if (m_tvalid && m_tready) begin
          if (grant != 2'b01 && grant != 2'b10) begin
            chk(1'b0, "grant_onehot", 64'(grant), 64'(1));
          end else begin
            gp = (grant == 2'b10) ? 1 : 0;
            if (exp_q[gp].size() == 0) begin
              chk(1'b0, "unexpected_beat", m_tdata, 64'(0));
            end else begin
              e = exp_q[gp].pop_front();
              chk(m_tdata == e.data, "beat_data", m_tdata, e.data);
              chk(m_tkeep == e.keep, "beat_keep", 64'(m_tkeep), 64'(e.keep));
              chk(m_tlast == e.last, "beat_last", 64'(m_tlast), 64'(e.last));
              exp_ovf = e.forced;
            end
            if (first_beat && ord_q.size() > 0) begin
              eo = ord_q.pop_front();
              chk(gp == eo, "arb_order", 64'(gp), 64'(eo));
            end
          end
          first_beat = m_tlast;
          after_last = m_tlast;
        end
        stall_prev = m_tvalid && !m_tready;
        pd = m_tdata; pk = m_tkeep; pl = m_tlast;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    model_cnt[0] = '0;
    model_cnt[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por");
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Both ports saturated from reset: strict alternation starting with port 0.
    tr_mode = 0; gap_pct = 0;
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
    push_pkt(0, 3); push_pkt(1, 3); push_pkt(0, 3); push_pkt(1, 3);
    wait_quiet();
    check_counts("rr");

    // Port 0 back-to-back, port 1 idle.
    for (int i = 0; i < 4; i++) begin
      ord_q.push_back(0);
      push_pkt(0, $urandom_range(1, 4));
    end
    wait_quiet();
    check_counts("b2b");

    // Toggling backpressure over a 5-beat packet.
    tr_mode = 1;
    push_pkt(0, 5);
    wait_quiet();
    tr_mode = 0;

    // Truncation boundaries: MAX+2, exactly MAX, MAX+1, and a single beat.
    push_pkt(1, int'(MAX) + 2);
    wait_quiet();
    push_pkt(1, int'(MAX));
    wait_quiet();
    push_pkt(1, int'(MAX) + 1);
    push_pkt(0, 1);
    wait_quiet();
    check_counts("trunc");

    // Randomized traffic with source gaps and random backpressure.
    tr_mode = 2; gap_pct = 30;
    for (int i = 0; i < 40; i++) begin
      push_pkt(int'($urandom_range(0, 1)), $urandom_range(1, int'(MAX) + 3));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2;
    end
    wait_quiet();
    check_counts("rand");

    // Counter wrap: enough single-beat packets to roll the CW-bit counter over.
    tr_mode = 0; gap_pct = 0;
    for (int i = 0; i < 20; i++) push_pkt(0, 1);
    wait_quiet();
    check_counts("wrap");

    // Reset while beat 2 of a port-0 packet is on the bus.
    push_pkt(0, 5);
    n = 0;
    while (exp_q[0].size() > 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(n < 200, "mid_pkt_timeout", 64'(n), 64'(200));
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    src_q[0].delete();
    exp_q[0].delete();
    ord_q.delete();
    sv[0] = 1'b0;
    model_cnt[0] = '0;
    model_cnt[1] = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    ord_q.push_back(1);
    push_pkt(1, 3);
    wait_quiet();
    check_counts("post_rst");
    ord_q.push_back(0); ord_q.push_back(1);
    push_pkt(0, 2); push_pkt(1, 2);
    wait_quiet();
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_tx_pkt_arb.md
AXIS_TX_PKT_ARB -- requirements
Module: axis_tx_pkt_arb

Interface
REQ-001 Parameter MAX_PKT_BEATS, default 190, is the maximum number of 64-bit beats per packet (1518 B rounded up).
REQ-002 Parameter CNT_W, default 16, is the width of the per-port packet counters.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 s0_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/64/8/1  requester 0 AXI-Stream slave.
REQ-006 s1_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/64/8/1  requester 1 AXI-Stream slave.
REQ-007 m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/64/8/1  master toward the LMAC TX s_axis port.
REQ-008 grant  out  2  one-hot active grant: bit0 = port 0, bit1 = port 1, 00 = none.
REQ-009 pkt_cnt0, pkt_cnt1  out  CNT_W each  packets forwarded per port.
REQ-010 oversize_err  out  1  one-cycle pulse when a packet is truncated.

Function
REQ-011 The FSM SHALL have five states: IDLE, GRANT0, GRANT1, DISCARD0, DISCARD1.
REQ-012 IDLE: s0/s1 tready = 0, m_axis_tvalid = 0, grant = 00.
REQ-013 IDLE, only sN_tvalid = 1 -> GRANTN on the next cycle.
REQ-014 IDLE, both tvalid = 1 -> grant the port not equal to last_grant (round-robin).
REQ-015 last_grant SHALL be updated on entry to GRANTN; no entry leaves it unchanged.
REQ-016 GRANTN: m_axis_tvalid/tdata/tkeep = sN values, sN_tready = m_axis_tready, the other port's tready = 0, grant = one-hot N; no added latency on the beat path.
REQ-017 A grant is packet-locked: no switch occurs until the granted packet ends; a tvalid drop mid-packet holds the grant.
REQ-018 beat_cnt clears on entry to GRANTN and increments on each m_axis handshake.
REQ-019 m_axis_tlast = sN_tlast OR (beat_cnt == MAX_PKT_BEATS-1).
REQ-020 Handshake with sN_tlast = 1 -> IDLE; one idle bubble cycle always separates packets.
REQ-021 Handshake with forced tlast and sN_tlast = 0 -> DISCARDN.
REQ-022 On a forced-tlast handshake, oversize_err pulses high in the following cycle.
REQ-023 DISCARDN: sN_tready = 1, m_axis_tvalid = 0, grant = 00, input beats are dropped.
REQ-024 DISCARDN, sN_tvalid & sN_tlast = 1 -> IDLE.
REQ-025 pkt_cntN SHALL increment on every m_axis handshake with m_axis_tlast = 1 while in GRANTN, including a forced tlast.
REQ-026 pkt_cntN SHALL wrap modulo 2^CNT_W.
REQ-027 A single-beat packet (tlast on beat 0) SHALL be forwarded and counted normally.
REQ-028 m_axis_tready = 0 SHALL hold all outputs stable, and beat_cnt and the counters SHALL not advance.

Reset
REQ-029 On reset assertion, outputs SHALL immediately take these values: state = IDLE, last_grant = 1 (port 0 wins the first tie), beat_cnt = 0, pkt_cnt0 = pkt_cnt1 = 0, grant = 00, oversize_err = 0, m_axis_tvalid = 0, s0/s1 tready = 0.
REQ-030 Reset mid-packet SHALL abandon the packet with no tlast generated; the first post-reset packet is arbitrated fresh.

Verification
REQ-031 Both ports present 3-beat packets from reset, m_tready = 1 -> order is P0, P1, P0, P1; one bubble between packets; pkt_cnt0 = pkt_cnt1 = 2 after four packets.
REQ-032 Port 0 streams back-to-back, port 1 idle -> port 0 is granted every packet; grant = 01 during beats, 00 in bubbles.
REQ-033 m_tready toggles 1/0 each cycle during a 5-beat packet -> 5 beats arrive unchanged in order; tlast on beat 5 only.
REQ-034 MAX_PKT_BEATS = 4, port 1 sends 6 beats -> 4 beats out with tlast on beat 4; oversize_err pulses once; beats 5-6 consumed silently; pkt_cnt1 += 1.
REQ-035 Reset asserted on beat 2 of a port-0 packet -> outputs go to reset values immediately; after release, a port-1 packet is forwarded first if only port 1 is valid.
REQ-036 pkt_cnt0 preloaded to 0xFFFF via 65535 packets (or force) plus one more packet -> pkt_cnt0 = 0x0000.
